// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : RV64I load/store unit. Sub-word stores are read-modify-write.
//            Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [63:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic        WE,
    output logic [63:0] A,
    output logic [63:0] WD,
    input  logic [63:0] RD
);

    localparam logic [63:0] c_addr_mask = (64'(MEM_WORDS) * 64'd8) - 64'd1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_fault;
    logic [63:0] r_merge;
    logic [63:0] r_addr;

    logic        w_accept;
    logic        w_illegal;
    logic        w_trap;
    logic        w_load_ok;
    logic        w_store_d;
    logic        w_store_rmw;
    logic [2:0]  w_align_mask;
    logic [63:0] w_addr_eff;
    logic [63:0] w_addr_mem;
    logic [2:0]  w_lane;
    logic [7:0]  w_byte_en;
    logic [63:0] w_bit_en;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_merged;
    logic [63:0] w_rd_sh;
    logic [63:0] w_ext;

    assign req_ready   = (r_state == IDLE);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign fault       = r_fault;

    // Gating with rst_n keeps WE low while reset is held, even in IDLE.
    assign w_accept  = req_valid && req_ready && rst_n;
    assign w_illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

    always_comb begin
        w_align_mask = 3'b000;
        case (req_funct3[1:0])
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            2'd3:    w_align_mask = 3'b111;
            default: w_align_mask = 3'b000;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap     = (req_addr[2:0] & w_align_mask) != 3'b000;
    assign w_addr_eff = req_addr;
`else
    assign w_trap     = 1'b0;
    assign w_addr_eff = req_addr & ~{61'd0, w_align_mask};
`endif

    assign w_addr_mem  = w_addr_eff & c_addr_mask;
    assign w_lane      = w_addr_eff[2:0];
    assign w_load_ok   = w_accept && !req_we && !w_illegal && !w_trap;
    assign w_store_d   = w_accept && req_we && !w_illegal && !w_trap && (req_funct3[1:0] == 2'd3);
    assign w_store_rmw = w_accept && req_we && !w_illegal && !w_trap && (req_funct3[1:0] != 2'd3);

    // Store merge: replace only the addressed bytes of the current word.
    always_comb begin
        w_byte_en = 8'h00;
        case (req_funct3[1:0])
            2'd0:    w_byte_en = 8'h01;
            2'd1:    w_byte_en = 8'h03;
            2'd2:    w_byte_en = 8'h0F;
            default: w_byte_en = 8'hFF;
        endcase
        w_byte_en = w_byte_en << w_lane;
        w_bit_en  = 64'd0;
        for (int i = 0; i < 8; i++) begin
            w_bit_en[i*8 +: 8] = {8{w_byte_en[i]}};
        end
        w_wdata_sh = req_wdata << {w_lane, 3'b000};
        w_merged   = (RD & ~w_bit_en) | (w_wdata_sh & w_bit_en);
    end

    always_comb begin
        w_rd_sh = RD >> {w_lane, 3'b000};
        w_ext   = w_rd_sh;
        case (req_funct3)
            3'b000:  w_ext = {{56{w_rd_sh[7]}},  w_rd_sh[7:0]};
            3'b001:  w_ext = {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
            3'b010:  w_ext = {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
            3'b100:  w_ext = {56'd0, w_rd_sh[7:0]};
            3'b101:  w_ext = {48'd0, w_rd_sh[15:0]};
            3'b110:  w_ext = {32'd0, w_rd_sh[31:0]};
            default: w_ext = w_rd_sh;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        WE          = 1'b0;
        A           = w_addr_mem;
        WD          = req_wdata;
        case (r_state)
            IDLE: begin
                WE = w_store_d;
                if (w_store_rmw) begin
                    w_state_nxt = RMW_WR;
                end
            end
            RMW_WR: begin
                WE          = 1'b1;
                A           = r_addr;
                WD          = r_merge;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rdata       <= 64'd0;
            r_rdata_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_merge       <= 64'd0;
            r_addr        <= 64'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_rdata_valid <= w_load_ok;
            r_fault       <= w_accept && (w_illegal || w_trap);
            if (w_load_ok) begin
                r_rdata <= w_ext;
            end
            if (w_store_rmw) begin
                r_merge <= w_merged;
                r_addr  <= w_addr_mem;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed vector bench for mem_access_unit with a behavioural RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic        WE;
    logic [63:0] A;
    logic [63:0] WD;
    logic [63:0] RD;

    logic [63:0] mem [0:1023];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (WE) mem[A[12:3]] <= WD;
    assign RD = mem[A[12:3]];

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .fault(fault), .WE(WE), .A(A), .WD(WD), .RD(RD)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_we;
        logic        rmw;
        logic        exp_valid;
        logic [63:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic apply(input vec_t v, input string nm);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        check({nm, " ready"}, {63'd0, req_ready}, 64'd1);
        #3;
        check({nm, " WE"}, {63'd0, WE}, {63'd0, v.exp_we});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        check({nm, " valid"}, {63'd0, rdata_valid}, {63'd0, v.exp_valid});
        check({nm, " fault"}, {63'd0, fault}, {63'd0, v.exp_fault});
        if (v.exp_valid) check({nm, " rdata"}, rdata, v.exp_rdata);
        if (v.rmw) begin
            check({nm, " rmw ready"}, {63'd0, req_ready}, 64'd0);
            check({nm, " rmw WE"}, {63'd0, WE}, 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;

        //             we f3      addr                   wdata                  WE rmw vld rdata                  flt
        vecs.push_back('{1, 3'b011, 64'h10,               64'h1122334455667788, 1, 0, 0, 64'h0,                0});
        vecs.push_back('{0, 3'b011, 64'h10,               64'h0,                0, 0, 1, 64'h1122334455667788, 0});
        vecs.push_back('{1, 3'b000, 64'h13,               64'hAB,               0, 1, 0, 64'h0,                0});
        vecs.push_back('{0, 3'b100, 64'h13,               64'h0,                0, 0, 1, 64'h00000000000000AB, 0});
        vecs.push_back('{0, 3'b000, 64'h13,               64'h0,                0, 0, 1, 64'hFFFFFFFFFFFFFFAB, 0});
        vecs.push_back('{0, 3'b011, 64'h10,               64'h0,                0, 0, 1, 64'h11223344AB667788, 0});
        vecs.push_back('{1, 3'b010, 64'h14,               64'h5555555580000000, 0, 1, 0, 64'h0,                0});
        vecs.push_back('{0, 3'b010, 64'h14,               64'h0,                0, 0, 1, 64'hFFFFFFFF80000000, 0});
        vecs.push_back('{0, 3'b110, 64'h14,               64'h0,                0, 0, 1, 64'h0000000080000000, 0});
        vecs.push_back('{0, 3'b011, 64'h10,               64'h0,                0, 0, 1, 64'h80000000AB667788, 0});
        vecs.push_back('{0, 3'b100, 64'h17,               64'h0,                0, 0, 1, 64'h0000000000000080, 0});
        vecs.push_back('{0, 3'b000, 64'h17,               64'h0,                0, 0, 1, 64'hFFFFFFFFFFFFFF80, 0});
        vecs.push_back('{0, 3'b101, 64'h16,               64'h0,                0, 0, 1, 64'h0000000000008000, 0});
        vecs.push_back('{0, 3'b001, 64'h16,               64'h0,                0, 0, 1, 64'hFFFFFFFFFFFF8000, 0});
        vecs.push_back('{1, 3'b001, 64'h20,               64'h1234,             0, 1, 0, 64'h0,                0});
        vecs.push_back('{1, 3'b001, 64'h22,               64'hBEEF,             0, 1, 0, 64'h0,                0});
        vecs.push_back('{0, 3'b101, 64'h22,               64'h0,                0, 0, 1, 64'h000000000000BEEF, 0});
        vecs.push_back('{0, 3'b001, 64'h22,               64'h0,                0, 0, 1, 64'hFFFFFFFFFFFFBEEF, 0});
        vecs.push_back('{0, 3'b011, 64'h20,               64'h0,                0, 0, 1, 64'h00000000BEEF1234, 0});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{0, 3'b001, 64'h21,               64'h0,                0, 0, 0, 64'h0,                1});
        vecs.push_back('{1, 3'b011, 64'h24,               64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 64'h0,                1});
`else
        vecs.push_back('{0, 3'b001, 64'h21,               64'h0,                0, 0, 1, 64'h0000000000001234, 0});
        vecs.push_back('{0, 3'b110, 64'h26,               64'h0,                0, 0, 1, 64'h0000000000000000, 0});
`endif
        vecs.push_back('{0, 3'b011, 64'h20,               64'h0,                0, 0, 1, 64'h00000000BEEF1234, 0});
        vecs.push_back('{0, 3'b011, 64'hFFFFFFFFFFFFE010, 64'h0,                0, 0, 1, 64'h80000000AB667788, 0});
        vecs.push_back('{0, 3'b111, 64'h10,               64'h0,                0, 0, 0, 64'h0,                1});
        vecs.push_back('{1, 3'b100, 64'h10,               64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 64'h0,                1});
        vecs.push_back('{1, 3'b111, 64'h10,               64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 64'h0,                1});
        vecs.push_back('{0, 3'b011, 64'h10,               64'h0,                0, 0, 1, 64'h80000000AB667788, 0});
        vecs.push_back('{1, 3'b011, 64'h2028,             64'h00000000CAFEF00D, 1, 0, 0, 64'h0,                0});
        vecs.push_back('{0, 3'b011, 64'h28,               64'h0,                0, 0, 1, 64'h00000000CAFEF00D, 0});

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst WE", {63'd0, WE}, 64'd0);
        check("rst valid", {63'd0, rdata_valid}, 64'd0);
        check("rst fault", {63'd0, fault}, 64'd0);
        check("rst rdata", rdata, 64'd0);
        rst_n = 1'b1;
        check("rst ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Idle cycle: no request means no write.
        #3;
        check("idle WE", {63'd0, WE}, 64'd0);
        @(posedge clk); #1;

        // Reset during RMW_WR abandons the pending sub-word write.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 64'h18; req_wdata = 64'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        check("rmw pending ready", {63'd0, req_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("rmw rst WE", {63'd0, WE}, 64'd0);
        check("rmw rst ready", {63'd0, req_ready}, 64'd1);
        check("rmw rst rdata", rdata, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("post rst ready", {63'd0, req_ready}, 64'd1);
        v = '{0, 3'b011, 64'h18, 64'h0, 0, 0, 1, 64'h0, 0};
        apply(v, "ld after rst");
        v = '{0, 3'b011, 64'h10, 64'h0, 0, 0, 1, 64'h80000000AB667788, 0};
        apply(v, "ld kept");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
